// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode enumeration and address-width helper.
package fifo_pkg;

   // Read-mode selector shared by the FIFO family.
   typedef enum logic {
      FIFO_STD  = 1'b0,
      FIFO_FWFT = 1'b1
   } fifo_mode_e;

   // Address width for a given depth; never narrower than one bit.
   function automatic int fifo_addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem_2p.sv
// Simple dual-port storage: synchronous write, asynchronous read.
// Kept separate so the array can be replaced by a vendor RAM macro.
module fifo_mem_2p
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   localparam int ADDR_W    = fifo_addr_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Store the incoming word on an accepted write; contents are never cleared.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule : fifo_mem_2p

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, threshold flags,
// sticky error flags and a selectable registered / first-word-fall-through read.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 32,
   parameter int AF_THRESH  = DEPTH - 4,
   parameter int AE_THRESH  = 4,
   parameter int FWFT       = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_en,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic                    rd_en,
   output logic [DATA_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int         ADDR_W = fifo_addr_w(DEPTH);
   localparam int         CNT_W  = ADDR_W + 1;
   localparam fifo_mode_e MODE   = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

   // Reject illegal configurations while elaborating.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("sync_fifo_param: DEPTH (%0d) must be a power of two >= 2", DEPTH);
   end
   if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("sync_fifo_param: AF_THRESH (%0d) must be in 1..DEPTH", AF_THRESH);
   end
   if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("sync_fifo_param: AE_THRESH (%0d) must be in 0..DEPTH-1", AE_THRESH);
   end

   logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] mem_rdata;

   // Flags come purely from registered state, so no request-to-flag path exists.
   assign empty        = (wr_ptr_q == rd_ptr_q);
   assign full         = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]) &&
                         (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
   assign almost_full  = (count_q >= CNT_W'(AF_THRESH));
   assign almost_empty = (count_q <= CNT_W'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Each request is judged against the current flags only.
   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk        (clk),
      .wr_en_i    (wr_ok),
      .wr_addr_i  (wr_ptr_q[ADDR_W-1:0]),
      .wr_data_i  (wr_data),
      .rd_addr_i  (rd_ptr_q[ADDR_W-1:0]),
      .rd_data_o  (mem_rdata)
   );

   // Next-state for pointers, occupancy and sticky error flags.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q  | (wr_en && full);
      underflow_d = underflow_q | (rd_en && empty);
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + (ADDR_W + 1)'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + (ADDR_W + 1)'(1);
      end
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // State register; reset empties the FIFO and clears the error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   if (MODE == FIFO_FWFT) begin : g_fwft
      // Head word is presented directly; zero while empty so rd_data is never X.
      assign rd_data  = empty ? '0 : mem_rdata;
      assign rd_valid = !empty;
   end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
      logic                  rd_valid_q, rd_valid_d;

      // Capture the head on an accepted read; otherwise hold the last word.
      always_comb begin
         rd_data_d  = rd_data_q;
         rd_valid_d = rd_ok;
         if (rd_ok) begin
            rd_data_d = mem_rdata;
         end
      end

      // Output register; reset drops any pending read result.
      always_ff @(posedge clk) begin
         if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
         end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
         end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
   end

endmodule : sync_fifo_param
